add_rs_issue: RTL and testbench
===============================

# add_rs_issue

Add/sub reservation-station issue unit for the Tomasulo core. It holds up to N_ENT add/sub operations from the decode/issue stage and captures pending operands from the common data bus (CDB). It selects one operand-ready entry at a time and dispatches it, with source data, to the add/sub execution unit. It frees the entry when that unit reports completion.

## Interface
- N_ENT, 3, number of reservation-station entries
- DW, 8, operand/result data width
- clk1 in 1 system clock, all state on rising edge
- rst_n in 1 reset, asynchronous, active-low
- alloc_v in 1 decode presents a new add/sub op this cycle
- alloc_rdy out 1 a free entry exists; alloc_v ignored when low
- alloc_func in 4 0000 add, 0001 sub; other codes stored and passed through
- alloc_rd in 4 destination register
- alloc_rob in 3 ROB index of the op; also the result tag
- alloc_s1_rdy / alloc_s2_rdy in 1 source operand value valid
- alloc_s1_val / alloc_s2_val in DW source value, used when rdy=1
- alloc_s1_tag / alloc_s2_tag in 3 producing ROB index, used when rdy=0
- cdb_v in 1 result broadcast valid
- cdb_rob in 3 ROB index of broadcast result
- cdb_data in DW broadcast result
- ex_b out 1 dispatch strobe, one-cycle pulse
- ex_rs_index out 3 entry number dispatched
- ex_rs1_data / ex_rs2_data out DW operands
- ex_func out 4, ex_rd out 4, ex_rob_ind out 3 op fields
- ex_done in 1 execution unit finished an op
- ex_done_idx in 3 entry number of finished op
- rs_count out $clog2(N_ENT+1) occupied entries

## Operation
- Entry states: FREE -> WAIT (any source not ready) -> READY -> ISSUED -> FREE.
- Allocation: on alloc_v && alloc_rdy, the lowest-index FREE entry is written. The state is READY if both sources are ready after bypass, otherwise WAIT.
- Allocation bypass: if cdb_v and cdb_rob equals a not-ready alloc tag in the same cycle, that source is captured from cdb_data as ready.
- Wakeup: each cycle, every WAIT entry with a not-ready source whose tag equals cdb_rob (cdb_v=1) latches cdb_data and marks that source ready. Both sources may wake in the same cycle. An entry becomes READY in the cycle after its last source is captured.
- Select: when the internal unit-busy flag is 0 and at least one entry is READY, the lowest-index READY entry is dispatched. Dispatch drives ex_b=1 with the entry's fields, moves the entry to ISSUED and sets the busy flag.
- Completion: ex_done moves entry ex_done_idx from ISSUED to FREE and clears the busy flag.
  - ex_done for an entry not in ISSUED is ignored.
- Only one op is in flight in the execution unit at any time.
- alloc_rdy = any entry FREE, derived from registered state only. A slot freed by ex_done becomes allocatable the next cycle.
- rs_count = number of non-FREE entries, registered.

## Timing
- Reset (async assert, sync-safe deassert): all entries FREE, busy=0, rs_count=0, alloc_rdy=1 after reset. ex_b=0 and all ex_* data/field outputs are 0.
- alloc with both sources ready at edge t: the op becomes READY at t. It can dispatch with ex_b high in cycle t+1 (one-cycle alloc-to-dispatch latency).
- ex_b is high for exactly one cycle per dispatch. ex_* fields are registered and hold their value until the next dispatch.
- ex_done in cycle t: busy clears at edge t. A READY entry can dispatch with ex_b in cycle t+1 (no bubble beyond that).
- Simultaneous alloc and ex_done are independent. Simultaneous wakeup and dispatch cannot target the same entry, because dispatch only considers READY entries.
- Reset mid-operation discards all entries and any in-flight dispatch. Any ex_done after reset is ignored.

## Structure
- Shared package holds: func codes (FUNC_ADD=4'b0000, FUNC_SUB=4'b0001), the entry-state enum, and the entry record typedef (func, rd, rob, s1/s2 ready, tag, value).
- One sub-module, rs_entry_wakeup: one instance per entry, doing per-entry CDB tag compare and operand capture. Select, allocation and busy tracking live in the top level.

## Test plan
- Reset then alloc add, s1=8'd5 ready, s2=8'd3 ready, rd=2, rob=1 -> ex_b pulses next cycle with rs1=5, rs2=3, func=0000, rd=2, rob_ind=1, rs_index=0; rs_count=1 until ex_done.
- Alloc sub with s2 tag=4 not ready; cdb_v, cdb_rob=4, data=8'd9 two cycles later -> dispatch one cycle after capture with rs2_data=9. A mismatched cdb_rob=5 causes no wakeup.
- Fill all 3 entries -> alloc_rdy=0; a fourth alloc_v is dropped and rs_count stays 3. ex_done frees entry 0 -> alloc_rdy=1 the next cycle and the new op lands in entry 0.
- Entries 1 and 2 READY while entry 0 is ISSUED -> no ex_b until ex_done; entry 1 then dispatches in the following cycle and entry 2 after entry 1's ex_done.
- Alloc with a not-ready tag equal to the same-cycle cdb_rob -> operand bypassed, dispatch the next cycle with the CDB value.
- Assert rst_n low while one entry is ISSUED and two are WAIT -> all outputs go to 0 immediately and alloc_rdy=1. A later ex_done produces no state change.

Source files
------------

// File: rtl/add_rs_issue_pkg.sv
// Shared types for the add/sub reservation station: func codes, entry state
// and the per-entry operand record.
package add_rs_issue_pkg;

  localparam int unsigned DW     = 8;
  localparam int unsigned TAG_W  = 3;
  localparam int unsigned FUNC_W = 4;
  localparam int unsigned RD_W   = 4;
  localparam int unsigned IDX_W  = 3;

  localparam logic [FUNC_W-1:0] FUNC_ADD = 4'b0000;
  localparam logic [FUNC_W-1:0] FUNC_SUB = 4'b0001;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_READY  = 2'd2,
    ST_ISSUED = 2'd3
  } ent_state_e;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [RD_W-1:0]   rd;
    logic [TAG_W-1:0]  rob;
    logic              s1_rdy;
    logic [TAG_W-1:0]  s1_tag;
    logic [DW-1:0]     s1_val;
    logic              s2_rdy;
    logic [TAG_W-1:0]  s2_tag;
    logic [DW-1:0]     s2_val;
  } rs_ent_t;

endpackage

// File: rtl/rs_entry_wakeup.sv
// Per-entry CDB snoop: captures any pending source whose tag matches the
// broadcast while the entry is waiting, and reports when both are ready.
module rs_entry_wakeup
  import add_rs_issue_pkg::*;
(
  input  logic             wait_i,
  input  rs_ent_t          ent_i,
  input  logic             cdb_v_i,
  input  logic [TAG_W-1:0] cdb_rob_i,
  input  logic [DW-1:0]    cdb_data_i,
  output rs_ent_t          ent_c,
  output logic             rdy_c
);

  always_comb begin
    ent_c = ent_i;
    if (wait_i && cdb_v_i) begin
      if (!ent_i.s1_rdy && (ent_i.s1_tag == cdb_rob_i)) begin
        ent_c.s1_rdy = 1'b1;
        ent_c.s1_val = cdb_data_i;
      end
      if (!ent_i.s2_rdy && (ent_i.s2_tag == cdb_rob_i)) begin
        ent_c.s2_rdy = 1'b1;
        ent_c.s2_val = cdb_data_i;
      end
    end
    rdy_c = ent_c.s1_rdy && ent_c.s2_rdy;
  end

endmodule

// File: rtl/add_rs_issue.sv
// Add/sub reservation station: allocation, CDB wakeup, lowest-index select
// and single-op-in-flight dispatch to the add/sub execution unit.
module add_rs_issue
  import add_rs_issue_pkg::*;
#(
  parameter int unsigned N_ENT = 3
) (
  input  logic                         clk1,
  input  logic                         rst_n,
  input  logic                         alloc_v,
  output logic                         alloc_rdy,
  input  logic [FUNC_W-1:0]            alloc_func,
  input  logic [RD_W-1:0]              alloc_rd,
  input  logic [TAG_W-1:0]             alloc_rob,
  input  logic                         alloc_s1_rdy,
  input  logic                         alloc_s2_rdy,
  input  logic [DW-1:0]                alloc_s1_val,
  input  logic [DW-1:0]                alloc_s2_val,
  input  logic [TAG_W-1:0]             alloc_s1_tag,
  input  logic [TAG_W-1:0]             alloc_s2_tag,
  input  logic                         cdb_v,
  input  logic [TAG_W-1:0]             cdb_rob,
  input  logic [DW-1:0]                cdb_data,
  output logic                         ex_b,
  output logic [IDX_W-1:0]             ex_rs_index,
  output logic [DW-1:0]                ex_rs1_data,
  output logic [DW-1:0]                ex_rs2_data,
  output logic [FUNC_W-1:0]            ex_func,
  output logic [RD_W-1:0]              ex_rd,
  output logic [TAG_W-1:0]             ex_rob_ind,
  input  logic                         ex_done,
  input  logic [IDX_W-1:0]             ex_done_idx,
  output logic [$clog2(N_ENT+1)-1:0]   rs_count
);

  localparam int unsigned CNT_W = $clog2(N_ENT + 1);

  ent_state_e state_q [N_ENT];
  ent_state_e state_d [N_ENT];
  rs_ent_t    ent_q   [N_ENT];
  rs_ent_t    ent_d   [N_ENT];
  rs_ent_t    ent_wk_c[N_ENT];
  logic       wk_rdy_c[N_ENT];
  rs_ent_t    alloc_ent_c;

  logic               busy_q, busy_d;
  logic               alloc_rdy_q, alloc_rdy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ex_b_q, ex_b_d;
  logic [IDX_W-1:0]   ex_idx_q, ex_idx_d;
  logic [DW-1:0]      ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic [FUNC_W-1:0]  ex_func_q, ex_func_d;
  logic [RD_W-1:0]    ex_rd_q, ex_rd_d;
  logic [TAG_W-1:0]   ex_rob_q, ex_rob_d;

  for (genvar g = 0; g < N_ENT; g++) begin : g_wk
    rs_entry_wakeup u_wk (
      .wait_i    (state_q[g] == ST_WAIT),
      .ent_i     (ent_q[g]),
      .cdb_v_i   (cdb_v),
      .cdb_rob_i (cdb_rob),
      .cdb_data_i(cdb_data),
      .ent_c     (ent_wk_c[g]),
      .rdy_c     (wk_rdy_c[g])
    );
  end

  // New entry record, with same-cycle CDB bypass on not-ready sources
  always_comb begin
    alloc_ent_c        = '0;
    alloc_ent_c.func   = alloc_func;
    alloc_ent_c.rd     = alloc_rd;
    alloc_ent_c.rob    = alloc_rob;
    alloc_ent_c.s1_rdy = alloc_s1_rdy;
    alloc_ent_c.s1_tag = alloc_s1_tag;
    alloc_ent_c.s1_val = alloc_s1_val;
    alloc_ent_c.s2_rdy = alloc_s2_rdy;
    alloc_ent_c.s2_tag = alloc_s2_tag;
    alloc_ent_c.s2_val = alloc_s2_val;
    if (cdb_v && !alloc_s1_rdy && (alloc_s1_tag == cdb_rob)) begin
      alloc_ent_c.s1_rdy = 1'b1;
      alloc_ent_c.s1_val = cdb_data;
    end
    if (cdb_v && !alloc_s2_rdy && (alloc_s2_tag == cdb_rob)) begin
      alloc_ent_c.s2_rdy = 1'b1;
      alloc_ent_c.s2_val = cdb_data;
    end
  end

  always_comb begin
    logic sel_found;
    logic alloc_found;
    for (int i = 0; i < N_ENT; i++) begin
      state_d[i] = state_q[i];
      ent_d[i]   = ent_q[i];
    end
    busy_d      = busy_q;
    ex_b_d      = 1'b0;
    ex_idx_d    = ex_idx_q;
    ex_rs1_d    = ex_rs1_q;
    ex_rs2_d    = ex_rs2_q;
    ex_func_d   = ex_func_q;
    ex_rd_d     = ex_rd_q;
    ex_rob_d    = ex_rob_q;
    sel_found   = 1'b0;
    alloc_found = 1'b0;
    cnt_d       = '0;
    alloc_rdy_d = 1'b0;

    // Each branch below touches a disjoint set of entry states
    for (int i = 0; i < N_ENT; i++) begin
      if (state_q[i] == ST_WAIT) begin
        ent_d[i] = ent_wk_c[i];
        if (wk_rdy_c[i]) state_d[i] = ST_READY;
      end
      if (ex_done && (ex_done_idx == IDX_W'(i)) && (state_q[i] == ST_ISSUED)) begin
        state_d[i] = ST_FREE;
        busy_d     = 1'b0;
      end
      if (!busy_q && !sel_found && (state_q[i] == ST_READY)) begin
        sel_found  = 1'b1;
        state_d[i] = ST_ISSUED;
        busy_d     = 1'b1;
        ex_b_d     = 1'b1;
        ex_idx_d   = IDX_W'(i);
        ex_rs1_d   = ent_q[i].s1_val;
        ex_rs2_d   = ent_q[i].s2_val;
        ex_func_d  = ent_q[i].func;
        ex_rd_d    = ent_q[i].rd;
        ex_rob_d   = ent_q[i].rob;
      end
      if (alloc_v && !alloc_found && (state_q[i] == ST_FREE)) begin
        alloc_found = 1'b1;
        ent_d[i]    = alloc_ent_c;
        state_d[i]  = (alloc_ent_c.s1_rdy && alloc_ent_c.s2_rdy) ? ST_READY : ST_WAIT;
      end
    end

    for (int i = 0; i < N_ENT; i++) begin
      if (state_d[i] != ST_FREE) cnt_d = cnt_d + CNT_W'(1);
      else                       alloc_rdy_d = 1'b1;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENT; i++) begin
        state_q[i] <= ST_FREE;
        ent_q[i]   <= '0;
      end
      busy_q      <= 1'b0;
      alloc_rdy_q <= 1'b1;
      cnt_q       <= '0;
      ex_b_q      <= 1'b0;
      ex_idx_q    <= '0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_func_q   <= '0;
      ex_rd_q     <= '0;
      ex_rob_q    <= '0;
    end else begin
      for (int i = 0; i < N_ENT; i++) begin
        state_q[i] <= state_d[i];
        ent_q[i]   <= ent_d[i];
      end
      busy_q      <= busy_d;
      alloc_rdy_q <= alloc_rdy_d;
      cnt_q       <= cnt_d;
      ex_b_q      <= ex_b_d;
      ex_idx_q    <= ex_idx_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      ex_func_q   <= ex_func_d;
      ex_rd_q     <= ex_rd_d;
      ex_rob_q    <= ex_rob_d;
    end
  end

  assign alloc_rdy   = alloc_rdy_q;
  assign rs_count    = cnt_q;
  assign ex_b        = ex_b_q;
  assign ex_rs_index = ex_idx_q;
  assign ex_rs1_data = ex_rs1_q;
  assign ex_rs2_data = ex_rs2_q;
  assign ex_func     = ex_func_q;
  assign ex_rd       = ex_rd_q;
  assign ex_rob_ind  = ex_rob_q;

endmodule

// File: tb/tb_add_rs_issue.sv
// Directed bench for add_rs_issue: dispatch latency, wakeup, full station,
// busy back-pressure, allocation bypass and mid-operation reset.
module tb_add_rs_issue;
  import add_rs_issue_pkg::*;

  logic             clk1 = 1'b0;
  logic             rst_n;
  logic             alloc_v, alloc_rdy;
  logic [3:0]       alloc_func, alloc_rd;
  logic [2:0]       alloc_rob, alloc_s1_tag, alloc_s2_tag;
  logic             alloc_s1_rdy, alloc_s2_rdy;
  logic [7:0]       alloc_s1_val, alloc_s2_val;
  logic             cdb_v;
  logic [2:0]       cdb_rob;
  logic [7:0]       cdb_data;
  logic             ex_b;
  logic [2:0]       ex_rs_index, ex_rob_ind;
  logic [7:0]       ex_rs1_data, ex_rs2_data;
  logic [3:0]       ex_func, ex_rd;
  logic             ex_done;
  logic [2:0]       ex_done_idx;
  logic [1:0]       rs_count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk1 = ~clk1;

  add_rs_issue #(.N_ENT(3)) dut (
    .clk1(clk1), .rst_n(rst_n),
    .alloc_v(alloc_v), .alloc_rdy(alloc_rdy), .alloc_func(alloc_func),
    .alloc_rd(alloc_rd), .alloc_rob(alloc_rob),
    .alloc_s1_rdy(alloc_s1_rdy), .alloc_s2_rdy(alloc_s2_rdy),
    .alloc_s1_val(alloc_s1_val), .alloc_s2_val(alloc_s2_val),
    .alloc_s1_tag(alloc_s1_tag), .alloc_s2_tag(alloc_s2_tag),
    .cdb_v(cdb_v), .cdb_rob(cdb_rob), .cdb_data(cdb_data),
    .ex_b(ex_b), .ex_rs_index(ex_rs_index), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_func(ex_func), .ex_rd(ex_rd),
    .ex_rob_ind(ex_rob_ind), .ex_done(ex_done), .ex_done_idx(ex_done_idx),
    .rs_count(rs_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic idle();
    alloc_v = 0; alloc_func = 0; alloc_rd = 0; alloc_rob = 0;
    alloc_s1_rdy = 0; alloc_s2_rdy = 0; alloc_s1_val = 0; alloc_s2_val = 0;
    alloc_s1_tag = 0; alloc_s2_tag = 0;
    cdb_v = 0; cdb_rob = 0; cdb_data = 0;
    ex_done = 0; ex_done_idx = 0;
  endtask

  task automatic alloc(input logic [3:0] f, input logic [3:0] rd, input logic [2:0] rob,
                       input logic r1, input logic [7:0] v1, input logic [2:0] t1,
                       input logic r2, input logic [7:0] v2, input logic [2:0] t2);
    alloc_v = 1; alloc_func = f; alloc_rd = rd; alloc_rob = rob;
    alloc_s1_rdy = r1; alloc_s1_val = v1; alloc_s1_tag = t1;
    alloc_s2_rdy = r2; alloc_s2_val = v2; alloc_s2_tag = t2;
  endtask

  task automatic cdb(input logic [2:0] rob, input logic [7:0] d);
    cdb_v = 1; cdb_rob = rob; cdb_data = d;
  endtask

  task automatic done(input logic [2:0] idx);
    ex_done = 1; ex_done_idx = idx;
  endtask

  initial begin
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk1);
    #1;
    check("rst_alloc_rdy", alloc_rdy, 1);
    check("rst_count", rs_count, 0);
    check("rst_ex_b", ex_b, 0);
    check("rst_rs1", ex_rs1_data, 0);
    @(negedge clk1) rst_n = 1;
    tick();

    // basic add, both sources ready
    alloc(FUNC_ADD, 4'd2, 3'd1, 1, 8'd5, 3'd0, 1, 8'd3, 3'd0);
    tick(); idle();
    check("t1_ex_b_early", ex_b, 0);
    check("t1_count", rs_count, 1);
    tick();
    check("t1_ex_b", ex_b, 1);
    check("t1_rs1", ex_rs1_data, 5);
    check("t1_rs2", ex_rs2_data, 3);
    check("t1_func", ex_func, 0);
    check("t1_rd", ex_rd, 2);
    check("t1_rob", ex_rob_ind, 1);
    check("t1_idx", ex_rs_index, 0);
    tick();
    check("t1_pulse", ex_b, 0);
    check("t1_hold_rs1", ex_rs1_data, 5);
    check("t1_count_inflight", rs_count, 1);
    done(3'd0); tick(); idle();
    check("t1_count_done", rs_count, 0);

    // sub waiting on tag 4; tag 5 must not wake it
    alloc(FUNC_SUB, 4'd3, 3'd2, 1, 8'd20, 3'd0, 0, 8'd0, 3'd4);
    tick(); idle();
    check("t2_count", rs_count, 1);
    cdb(3'd5, 8'd77); tick(); idle();
    tick();
    check("t2_no_wake", ex_b, 0);
    cdb(3'd4, 8'd9); tick(); idle();
    check("t2_capture_no_b", ex_b, 0);
    tick();
    check("t2_ex_b", ex_b, 1);
    check("t2_rs1", ex_rs1_data, 20);
    check("t2_rs2", ex_rs2_data, 9);
    check("t2_func", ex_func, 1);
    check("t2_rd", ex_rd, 3);
    done(3'd0); tick(); idle();

    // fill the station, all waiting on tag 7
    alloc(FUNC_ADD, 4'd4, 3'd3, 1, 8'd30, 3'd0, 0, 8'd0, 3'd7); tick();
    alloc(FUNC_ADD, 4'd5, 3'd4, 1, 8'd31, 3'd0, 0, 8'd0, 3'd7); tick();
    alloc(FUNC_SUB, 4'd6, 3'd5, 1, 8'd32, 3'd0, 0, 8'd0, 3'd7); tick();
    check("t3_full_rdy", alloc_rdy, 0);
    check("t3_full_count", rs_count, 3);
    alloc(FUNC_ADD, 4'd7, 3'd6, 1, 8'd1, 3'd0, 1, 8'd1, 3'd0); tick(); idle();
    check("t3_drop_count", rs_count, 3);
    done(3'd0); tick(); idle();
    check("t3_done_wait_ignored", rs_count, 3);
    cdb(3'd7, 8'd40); tick(); idle();
    tick();
    check("t3_ex_b0", ex_b, 1);
    check("t3_idx0", ex_rs_index, 0);
    check("t3_rob0", ex_rob_ind, 3);
    check("t3_rs1_0", ex_rs1_data, 30);
    check("t3_rs2_0", ex_rs2_data, 40);
    tick();
    check("t4_busy_a", ex_b, 0);
    tick();
    check("t4_busy_b", ex_b, 0);
    done(3'd0); tick(); idle();
    check("t3_rdy_after_done", alloc_rdy, 1);
    check("t3_count_after_done", rs_count, 2);
    check("t4_no_b_on_done", ex_b, 0);
    alloc(FUNC_SUB, 4'd8, 3'd6, 1, 8'd1, 3'd0, 0, 8'd0, 3'd0);
    tick(); idle();
    check("t4_ex_b1", ex_b, 1);
    check("t4_idx1", ex_rs_index, 1);
    check("t4_rob1", ex_rob_ind, 4);
    check("t3_refill_count", rs_count, 3);
    tick();
    check("t4_busy_c", ex_b, 0);
    done(3'd1); tick(); idle();
    check("t4_count_d1", rs_count, 2);
    tick();
    check("t4_ex_b2", ex_b, 1);
    check("t4_idx2", ex_rs_index, 2);
    check("t4_rs1_2", ex_rs1_data, 32);
    done(3'd2); tick(); idle();
    check("t4_count_d2", rs_count, 1);
    cdb(3'd0, 8'd11); tick(); idle();
    tick();
    check("t3_new_ex_b", ex_b, 1);
    check("t3_new_idx", ex_rs_index, 0);
    check("t3_new_rob", ex_rob_ind, 6);
    check("t3_new_rs2", ex_rs2_data, 11);
    done(3'd0); tick(); idle();
    check("t3_empty", rs_count, 0);

    // same-cycle CDB bypass into allocation
    alloc(FUNC_ADD, 4'd9, 3'd2, 0, 8'd0, 3'd6, 1, 8'd4, 3'd0);
    cdb(3'd6, 8'd100);
    tick(); idle();
    tick();
    check("t5_ex_b", ex_b, 1);
    check("t5_rs1", ex_rs1_data, 100);
    check("t5_rs2", ex_rs2_data, 4);
    done(3'd0); tick(); idle();

    // reset with one issued, two waiting
    alloc(FUNC_ADD, 4'd5, 3'd1, 1, 8'd12, 3'd0, 1, 8'd13, 3'd0); tick();
    alloc(FUNC_ADD, 4'd6, 3'd2, 1, 8'd1, 3'd0, 0, 8'd0, 3'd7); tick();
    check("t6_ex_b", ex_b, 1);
    check("t6_rs1", ex_rs1_data, 12);
    alloc(FUNC_SUB, 4'd7, 3'd3, 1, 8'd2, 3'd0, 0, 8'd0, 3'd7); tick(); idle();
    check("t6_count_pre", rs_count, 3);
    #2 rst_n = 0;
    #1;
    check("t6_rst_rs1", ex_rs1_data, 0);
    check("t6_rst_rd", ex_rd, 0);
    check("t6_rst_rob", ex_rob_ind, 0);
    check("t6_rst_count", rs_count, 0);
    check("t6_rst_alloc_rdy", alloc_rdy, 1);
    check("t6_rst_ex_b", ex_b, 0);
    @(negedge clk1) rst_n = 1;
    done(3'd0); tick(); idle();
    check("t6_done_ignored", rs_count, 0);
    check("t6_rdy_after", alloc_rdy, 1);
    cdb(3'd7, 8'd55); tick(); idle();
    tick();
    check("t6_no_dispatch", ex_b, 0);
    check("t6_count_end", rs_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
